// File: rtl/ara_eoc_pkg.sv
// Shared types and default addresses for the end-of-computation monitor.
// aw_entry_t records what an accepted write address means for the W beats that follow it.
package ara_eoc_pkg;

  localparam int unsigned DefAddrWidth   = 64;
  localparam int unsigned DefDataWidth   = 512;
  localparam int unsigned DefAwFifoDepth = 4;
  localparam int          LaneW          = $clog2(DefDataWidth / 8) - 3;

  localparam logic [63:0] DefToHostAddr = 64'h8000_1000;
  localparam logic [63:0] DefTimerAddr  = 64'h8000_1008;

  typedef struct packed {
    logic             is_tohost;
    logic             is_timer;
    logic [LaneW-1:0] lane;
  } aw_entry_t;

endpackage

// File: rtl/ara_eoc_monitor_fifo.sv
// Small non-fall-through FIFO for decoded AW entries; the head is read straight from storage.
// A push is still accepted while full when a pop happens in the same cycle.
module ara_eoc_monitor_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntMax = (PtrW + 1)'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntMax);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrOne;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ara_eoc_monitor.sv
// Passive snooper on the wide AXI write path: catches tohost and runtime-timer stores and
// turns them into the exit word and cycle count the simulation top uses to stop.
module ara_eoc_monitor
  import ara_eoc_pkg::*;
#(
  parameter int unsigned          AddrWidth   = DefAddrWidth,
  parameter int unsigned          DataWidth   = DefDataWidth,
  parameter logic [AddrWidth-1:0] ToHostAddr  = AddrWidth'(DefToHostAddr),
  parameter logic [AddrWidth-1:0] TimerAddr   = AddrWidth'(DefTimerAddr),
  parameter int unsigned          AwFifoDepth = DefAwFifoDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aw_valid_i,
  input  logic                   aw_ready_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   w_valid_i,
  input  logic                   w_ready_i,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic [63:0]            exit_o,
  output logic [63:0]            runtime_o,
  output logic                   timer_run_o,
  output logic                   proto_err_o
);

  localparam int unsigned OffW   = $clog2(DataWidth / 8);
  localparam int unsigned EntryW = $bits(aw_entry_t);

  // A channel transfer happens only on a cycle where valid and ready are both high;
  // valid without ready (or ready without valid) is invisible to this monitor.
  logic aw_hs;
  logic w_hs;
  logic bypass;
  logic w_matched;
  logic w_orphan;
  logic aw_overflow;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic [EntryW-1:0] fifo_wdata;
  logic [EntryW-1:0] fifo_rdata;
  aw_entry_t aw_in;
  aw_entry_t head;

  logic                         decode;
  logic [$clog2(DataWidth)-1:0] word_base;
  logic [OffW-1:0]              strb_base;
  logic [63:0]                  word;
  logic                         strb_ok;

  logic [63:0] exit_q, exit_d;
  logic [63:0] runtime_q, runtime_d;
  logic [63:0] cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        err_q, err_d;
  logic        first_q, first_d;

  assign aw_hs = aw_valid_i & aw_ready_i;
  assign w_hs  = w_valid_i & w_ready_i;

  assign aw_in.is_tohost = (aw_addr_i == ToHostAddr);
  assign aw_in.is_timer  = (aw_addr_i == TimerAddr);
  assign aw_in.lane      = aw_addr_i[OffW-1:3];

  // With nothing queued, a W beat arriving alongside its AW uses the incoming entry.
  assign bypass      = w_hs & aw_hs & fifo_empty;
  assign w_matched   = w_hs & (~fifo_empty | aw_hs);
  assign w_orphan    = w_hs & fifo_empty & ~aw_hs;
  assign fifo_pop    = w_hs & w_last_i & ~fifo_empty;
  assign aw_overflow = aw_hs & fifo_full & ~fifo_pop;
  assign fifo_push   = aw_hs & ~aw_overflow & ~(bypass & w_last_i);
  assign fifo_wdata  = aw_in;
  assign head        = bypass ? aw_in : aw_entry_t'(fifo_rdata);

  ara_eoc_monitor_fifo #(
    .Width (EntryW),
    .Depth (AwFifoDepth)
  ) i_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign decode    = w_matched & first_q;
  assign word_base = {head.lane, 6'd0};
  assign strb_base = {head.lane, 3'd0};
  assign word      = w_data_i[word_base +: 64];
  assign strb_ok   = &w_strb_i[strb_base +: 8];

  always_comb begin
    exit_d    = exit_q;
    runtime_d = runtime_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    err_d     = err_q;
    first_d   = first_q;

    if (w_orphan || aw_overflow) begin
      err_d = 1'b1;
    end
    if (w_matched) begin
      first_d = w_last_i;
    end
    if (run_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 64'd1;
    end

    // Only a fully strobed first beat carries a meaningful word.
    if (decode && strb_ok) begin
      if (head.is_tohost && word[0] && !exit_q[0]) begin
        exit_d = word;
      end
      if (head.is_timer) begin
        if (word != '0) begin
          cnt_d = '0;
          run_d = 1'b1;
        end else if (run_q) begin
          runtime_d = cnt_q;
          run_d     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_q    <= '0;
      runtime_q <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      exit_q    <= exit_d;
      runtime_q <= runtime_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign exit_o      = exit_q;
  assign runtime_o   = runtime_q;
  assign timer_run_o = run_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Directed bench for ara_eoc_monitor: a per-cycle vector table followed by
// hand-written multi-cycle sequences (hold, long timer, FIFO depth, bursts, mid-burst reset).
module tb_ara_eoc_monitor;

  localparam logic [63:0] TH = 64'h8000_1000;
  localparam logic [63:0] TM = 64'h8000_1008;
  localparam logic [63:0] OT = 64'h8000_2000;
  localparam logic [63:0] NX = 64'h8000_1010;

  logic         clk;
  logic         rst;
  logic         aw_valid;
  logic         aw_ready;
  logic [63:0]  aw_addr;
  logic         w_valid;
  logic         w_ready;
  logic [511:0] w_data;
  logic [63:0]  w_strb;
  logic         w_last;
  logic [63:0]  exit_w;
  logic [63:0]  runtime_w;
  logic         run_w;
  logic         err_w;

  int n_tests = 0;
  int n_fail  = 0;

  ara_eoc_monitor dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .aw_valid_i  (aw_valid),
    .aw_ready_i  (aw_ready),
    .aw_addr_i   (aw_addr),
    .w_valid_i   (w_valid),
    .w_ready_i   (w_ready),
    .w_data_i    (w_data),
    .w_strb_i    (w_strb),
    .w_last_i    (w_last),
    .exit_o      (exit_w),
    .runtime_o   (runtime_w),
    .timer_run_o (run_w),
    .proto_err_o (err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        awv;
    logic        awr;
    logic [63:0] addr;
    logic        wv;
    logic        wr;
    logic [63:0] word;
    logic [2:0]  lane;
    logic [7:0]  strb;
    logic        last;
    logic [63:0] e_exit;
    logic [63:0] e_rt;
    logic        e_run;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic r, input logic awv, input logic awr,
                              input logic [63:0] addr, input logic wv, input logic wr,
                              input logic [63:0] word, input logic [2:0] lane,
                              input logic [7:0] strb, input logic last,
                              input logic [63:0] e_exit, input logic [63:0] e_rt,
                              input logic e_run, input logic e_err);
    vec_t v;
    v.name = nm; v.rst = r; v.awv = awv; v.awr = awr; v.addr = addr;
    v.wv = wv; v.wr = wr; v.word = word; v.lane = lane; v.strb = strb; v.last = last;
    v.e_exit = e_exit; v.e_rt = e_rt; v.e_run = e_run; v.e_err = e_err;
    return v;
  endfunction

  // Other lanes carry 5 (bit0 set, nonzero) so a wrong-lane decode shows up.
  task automatic drive(input logic awv, input logic [63:0] addr, input logic wv,
                       input logic [63:0] word, input logic [2:0] lane,
                       input logic [7:0] strb, input logic last);
    aw_valid = awv;
    aw_ready = 1'b1;
    aw_addr  = addr;
    w_valid  = wv;
    w_ready  = 1'b1;
    w_last   = last;
    w_strb   = '1;
    for (int i = 0; i < 8; i++) begin
      w_data[i*64 +: 64] = (i == int'(lane)) ? word : 64'h5;
      if (i == int'(lane)) w_strb[i*8 +: 8] = strb;
    end
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 64'h0, 3'd0, 8'hFF, 1'b0);
  endtask

  task automatic aw_only(input logic [63:0] addr);
    drive(1'b1, addr, 1'b0, 64'h0, 3'd0, 8'hFF, 1'b0);
  endtask

  task automatic w_only(input logic [63:0] word, input logic [2:0] lane, input logic last);
    drive(1'b0, 64'h0, 1'b1, word, lane, 8'hFF, last);
  endtask

  task automatic both(input logic [63:0] addr, input logic [63:0] word, input logic [2:0] lane,
                      input logic last);
    drive(1'b1, addr, 1'b1, word, lane, 8'hFF, last);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();

    vecs.push_back(mk("reset",           1, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("partial_strb",    0, 1, 1, TH,    1, 1, 64'h7, 0, 8'h0F, 1, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("tohost_bit0_0",   0, 1, 1, TH,    1, 1, 64'h6, 0, 8'hFF, 1, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("aw_not_ready",    0, 1, 0, TH,    0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("w_not_ready",     0, 0, 1, 64'h0, 1, 0, 64'h7, 0, 8'hFF, 1, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("aw_tohost",       0, 1, 1, TH,    0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("w_exit7",         0, 0, 1, 64'h0, 1, 1, 64'h7, 0, 8'hFF, 1, 64'h7, 64'h0, 0, 0));
    vecs.push_back(mk("exit_frozen",     0, 1, 1, TH,    1, 1, 64'h1, 0, 8'hFF, 1, 64'h7, 64'h0, 0, 0));
    vecs.push_back(mk("reset2",          1, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("timer_start",     0, 1, 1, TM,    1, 1, 64'h5, 1, 8'hFF, 1, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_idle",      0, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_stop",      0, 1, 1, TM,    1, 1, 64'h0, 1, 8'hFF, 1, 64'h0, 64'h1, 0, 0));
    vecs.push_back(mk("timer_stop_idle", 0, 1, 1, TM,    1, 1, 64'h0, 1, 8'hFF, 1, 64'h0, 64'h1, 0, 0));
    vecs.push_back(mk("non_tohost_addr", 0, 1, 1, NX,    1, 1, 64'h1, 2, 8'hFF, 1, 64'h0, 64'h1, 0, 0));
    vecs.push_back(mk("orphan_w",        0, 0, 1, 64'h0, 1, 1, 64'h1, 0, 8'hFF, 1, 64'h0, 64'h1, 0, 1));
    vecs.push_back(mk("decode_after_err",0, 1, 1, TH,    1, 1, 64'h3, 0, 8'hFF, 1, 64'h3, 64'h1, 0, 1));
    vecs.push_back(mk("reset3",          1, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 0, 0));
    vecs.push_back(mk("timer_start2",    0, 1, 1, TM,    1, 1, 64'h9, 1, 8'hFF, 1, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_idle2a",    0, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_idle2b",    0, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_restart",   0, 1, 1, TM,    1, 1, 64'h4, 1, 8'hFF, 1, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_idle2c",    0, 0, 1, 64'h0, 0, 1, 64'h0, 0, 8'hFF, 0, 64'h0, 64'h0, 1, 0));
    vecs.push_back(mk("timer_stop2",     0, 1, 1, TM,    1, 1, 64'h0, 1, 8'hFF, 1, 64'h0, 64'h1, 0, 0));

    foreach (vecs[k]) begin
      rst = vecs[k].rst;
      if (vecs[k].rst) begin
        idle();
      end else begin
        drive(vecs[k].awv, vecs[k].addr, vecs[k].wv, vecs[k].word, vecs[k].lane,
              vecs[k].strb, vecs[k].last);
        aw_ready = vecs[k].awr;
        w_ready  = vecs[k].wr;
      end
      tick();
      chk({vecs[k].name, ".exit"},    exit_w,           vecs[k].e_exit);
      chk({vecs[k].name, ".runtime"}, runtime_w,        vecs[k].e_rt);
      chk({vecs[k].name, ".run"},     64'(run_w),       64'(vecs[k].e_run));
      chk({vecs[k].name, ".err"},     64'(err_w),       64'(vecs[k].e_err));
    end
    rst = 1'b0;

    // Exit word of 1 appears one cycle after the W beat and then holds.
    do_reset();
    aw_only(TH); tick();
    chk("hold.pre", exit_w, 64'h0);
    w_only(64'h1, 3'd0, 1'b1); tick();
    chk("hold.exit", exit_w, 64'h1);
    idle();
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("hold.cycle", exit_w, 64'h1);
    end

    // Timer with 250 idle cycles between start and stop handshakes.
    do_reset();
    both(TM, 64'h1, 3'd1, 1'b1); tick();
    chk("t250.run", 64'(run_w), 64'h1);
    idle();
    for (int i = 0; i < 250; i++) tick();
    both(TM, 64'h0, 3'd1, 1'b1); tick();
    chk("t250.runtime", runtime_w, 64'd250);
    chk("t250.stopped", 64'(run_w), 64'h0);

    // Four AWs queue cleanly; a fifth overflows; queued entries decode in order.
    do_reset();
    aw_only(TM); tick();
    aw_only(TM); tick();
    aw_only(TH); tick();
    aw_only(OT); tick();
    chk("fifo.four_ok", 64'(err_w), 64'h0);
    aw_only(TH); tick();
    chk("fifo.overflow", 64'(err_w), 64'h1);
    w_only(64'h1, 3'd1, 1'b1); tick();
    chk("fifo.e0_start", 64'(run_w), 64'h1);
    idle(); tick();
    w_only(64'h0, 3'd1, 1'b1); tick();
    chk("fifo.e1_stop", 64'(run_w), 64'h0);
    chk("fifo.e1_rt", runtime_w, 64'h1);
    w_only(64'hB, 3'd0, 1'b1); tick();
    chk("fifo.e2_exit", exit_w, 64'hB);
    w_only(64'h2, 3'd0, 1'b1); tick();
    chk("fifo.e3_other", exit_w, 64'hB);

    // Four-beat tohost burst: only beat0 (v=0) is decoded.
    do_reset();
    aw_only(TH); tick();
    w_only(64'h0, 3'd0, 1'b0); tick();
    w_only(64'h1, 3'd0, 1'b0); tick();
    w_only(64'h1, 3'd0, 1'b0); tick();
    w_only(64'h1, 3'd0, 1'b1); tick();
    chk("burst.exit", exit_w, 64'h0);
    chk("burst.err", 64'(err_w), 64'h0);
    both(TH, 64'h1, 3'd0, 1'b1); tick();
    chk("burst.next_first", exit_w, 64'h1);

    // Bypass on a multi-beat burst must keep the entry for the later beats.
    do_reset();
    both(TH, 64'h0, 3'd0, 1'b0); tick();
    w_only(64'h1, 3'd0, 1'b0); tick();
    w_only(64'h1, 3'd0, 1'b1); tick();
    chk("bypass_burst.exit", exit_w, 64'h0);
    chk("bypass_burst.err", 64'(err_w), 64'h0);
    aw_only(TH); tick();
    w_only(64'h1, 3'd0, 1'b1); tick();
    chk("bypass_burst.after", exit_w, 64'h1);

    // Reset in the middle of a burst; the tail of that burst is orphaned.
    do_reset();
    both(TM, 64'h1, 3'd1, 1'b1); tick();
    chk("midrst.run", 64'(run_w), 64'h1);
    aw_only(TH); tick();
    w_only(64'h0, 3'd0, 1'b0); tick();
    w_only(64'h0, 3'd0, 1'b0); tick();
    do_reset();
    chk("midrst.run0", 64'(run_w), 64'h0);
    chk("midrst.exit0", exit_w, 64'h0);
    chk("midrst.err0", 64'(err_w), 64'h0);
    w_only(64'h1, 3'd0, 1'b0); tick();
    chk("midrst.tail_err", 64'(err_w), 64'h1);
    w_only(64'h1, 3'd0, 1'b1); tick();
    chk("midrst.tail_exit", exit_w, 64'h0);
    chk("midrst.sticky", 64'(err_w), 64'h1);
    idle(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
